// File: rtl/event_fifo_serializer.sv
// event_fifo_serializer: collects spike events from several detector units,
// stamps each with a free-running sample timestamp, queues the 16-bit records
// in a small FIFO and serializes the head record as MSB then LSB bytes under
// reader handshake. Dropped spikes are tracked by a sticky flag and a
// saturating counter.
module event_fifo_serializer #(
  parameter int NUM_UNITS  = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic [NUM_UNITS-1:0]   spike_in,
  input  logic [2*NUM_UNITS-1:0] event_in,
  input  logic                   byte_ack,
  input  logic                   clear_status,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  output logic                   byte_phase,
  output logic [3:0]             fifo_count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = 16;

  typedef enum logic {
    PH_MSB = 1'b0,
    PH_LSB = 1'b1
  } phase_t;

  // Record layout: [15] unit index, [14:13] event code, [12:0] timestamp.
  function automatic logic [REC_W-1:0] make_rec(input logic uidx,
                                                input logic [1:0] ev,
                                                input logic [TS_WIDTH-1:0] ts);
    return {uidx, ev, ts};
  endfunction

  // Saturating add used for the drop counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] base,
                                          input logic [7:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [NUM_UNITS-1:0] pend_vld_q, pend_vld_d;
  logic [REC_W-1:0]     pend_rec_q [NUM_UNITS];
  logic [REC_W-1:0]     pend_rec_d [NUM_UNITS];
  logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [3:0]           count_q, count_d;
  phase_t               phase_q, phase_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic                 wr_en;
  logic [NUM_UNITS-1:0] wr_sel;
  logic [REC_W-1:0]     wr_rec;
  logic [NUM_UNITS-1:0] drops;
  logic [7:0]           n_drops;
  logic                 pop;
  logic [REC_W-1:0]     head;

  // Timestamp advances once per accepted input sample and wraps naturally.
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(sample_tick);
  end

  // Pick the lowest-index pending record; the gate uses the start-of-cycle
  // count so a coincident pop never frees a slot for this cycle's write.
  always_comb begin
    wr_en  = 1'b0;
    wr_sel = '0;
    wr_rec = '0;
    if (count_q < 4'(FIFO_DEPTH)) begin
      for (int k = NUM_UNITS - 1; k >= 0; k--) begin
        if (pend_vld_q[k]) begin
          wr_en     = 1'b1;
          wr_sel    = '0;
          wr_sel[k] = 1'b1;
          wr_rec    = pend_rec_q[k];
        end
      end
    end
  end

  // Pending register per unit: reload when empty or being written this
  // cycle, otherwise the new spike is discarded and counted as a drop.
  always_comb begin
    pend_vld_d = pend_vld_q;
    drops      = '0;
    n_drops    = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      pend_rec_d[k] = pend_rec_q[k];
      if (wr_sel[k]) begin
        pend_vld_d[k] = 1'b0;
      end
      if (spike_in[k]) begin
        if (!pend_vld_q[k] || wr_sel[k]) begin
          pend_vld_d[k] = 1'b1;
          pend_rec_d[k] = make_rec(1'(k), event_in[2*k +: 2], ts_q);
        end else begin
          drops[k] = 1'b1;
          n_drops  = n_drops + 8'd1;
        end
      end
    end
  end

  // Status: a drop in the clearing cycle survives the clear.
  always_comb begin
    overflow_d = (|drops) | (overflow_q & ~clear_status);
    drop_cnt_d = sat_add8(clear_status ? 8'd0 : drop_cnt_q, n_drops);
  end

  // Readout FSM next-state: MSB -> LSB on ack, LSB -> MSB with pop on ack.
  always_comb begin
    phase_d = phase_q;
    pop     = 1'b0;
    case (phase_q)
      PH_MSB: begin
        if (byte_ack && out_valid) begin
          phase_d = PH_LSB;
        end
      end
      PH_LSB: begin
        if (byte_ack && out_valid) begin
          pop     = 1'b1;
          phase_d = PH_MSB;
        end
      end
      default: phase_d = PH_MSB;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + 4'(wr_en) - 4'(pop);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      pend_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      phase_q    <= PH_MSB;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      pend_vld_q <= pend_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage; contents are qualified by the valid flags and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
    for (int k = 0; k < NUM_UNITS; k++) begin
      pend_rec_q[k] <= pend_rec_d[k];
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != 4'd0);
  assign out_byte   = !out_valid          ? 8'h00 :
                      (phase_q == PH_LSB) ? head[7:0] : head[15:8];
  assign byte_phase = (phase_q == PH_LSB);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_event_fifo_serializer.sv
// Directed bench for event_fifo_serializer with hand-computed expectations.
module tb_event_fifo_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic [1:0] spike_in;
  logic [3:0] event_in;
  logic       byte_ack;
  logic       clear_status;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       byte_phase;
  logic [3:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  event_fifo_serializer #(
    .NUM_UNITS(2), .FIFO_DEPTH(8), .TS_WIDTH(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .spike_in(spike_in), .event_in(event_in), .byte_ack(byte_ack),
    .clear_status(clear_status), .out_byte(out_byte), .out_valid(out_valid),
    .byte_phase(byte_phase), .fifo_count(fifo_count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 16'(out_valid), 16'h0);
    check({tag, "_byte"},  16'(out_byte),  16'h00);
    check({tag, "_phase"}, 16'(byte_phase), 16'h0);
    check({tag, "_count"}, 16'(fifo_count), 16'h0);
    check({tag, "_ovf"},   16'(overflow),  16'h0);
    check({tag, "_drop"},  16'(drop_cnt),  16'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic ack_once();
    byte_ack = 1'b1;
    step();
    byte_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; spike_in = 2'b00; event_in = 4'b0000;
    byte_ack = 1'b0; clear_status = 1'b0;
    #1;
    check_reset_outputs("por");
    step();
    rst_n = 1'b1;

    // Single spike after 5 ticks: record 0x4005.
    sample_tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    sample_tick = 1'b0;
    spike_in = 2'b01; event_in = 4'b0010;
    step();
    spike_in = 2'b00; event_in = 4'b0000;
    check("single_lat_n1", 16'(out_valid), 16'h0);
    step();
    check("single_valid", 16'(out_valid), 16'h1);
    check("single_msb", 16'(out_byte), 16'h40);
    check("single_phase0", 16'(byte_phase), 16'h0);
    check("single_count", 16'(fifo_count), 16'h1);
    ack_once();
    check("single_lsb", 16'(out_byte), 16'h05);
    check("single_phase1", 16'(byte_phase), 16'h1);
    ack_once();
    check("single_empty", 16'(out_valid), 16'h0);
    check("single_empty_byte", 16'(out_byte), 16'h00);
    check("single_phase_back", 16'(byte_phase), 16'h0);
    ack_once();
    check("ack_when_empty_phase", 16'(byte_phase), 16'h0);

    // Back-to-back spikes on one unit: reload during write, no drop.
    spike_in = 2'b01;
    step();
    step();
    spike_in = 2'b00;
    step();
    check("b2b_count", 16'(fifo_count), 16'h2);
    check("b2b_ovf", 16'(overflow), 16'h0);
    check("b2b_drop", 16'(drop_cnt), 16'h0);
    for (int i = 0; i < 4; i++) ack_once();
    check("b2b_drained", 16'(fifo_count), 16'h0);

    // Simultaneous spikes at ts=0: 0x6000 then 0xA000.
    do_reset();
    spike_in = 2'b11; event_in = 4'b0111;
    step();
    spike_in = 2'b00; event_in = 4'b0000;
    step();
    check("simul_count1", 16'(fifo_count), 16'h1);
    step();
    check("simul_count2", 16'(fifo_count), 16'h2);
    check("simul_r0_msb", 16'(out_byte), 16'h60);
    ack_once();
    check("simul_r0_lsb", 16'(out_byte), 16'h00);
    ack_once();
    check("simul_r1_msb", 16'(out_byte), 16'hA0);
    check("simul_r1_count", 16'(fifo_count), 16'h1);
    ack_once();
    check("simul_r1_lsb", 16'(out_byte), 16'h00);
    ack_once();
    check("simul_empty", 16'(fifo_count), 16'h0);

    // Full FIFO: 8 stored, 9th held, 10th dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      spike_in = 2'b01;
      step();
      spike_in = 2'b00;
      step();
    end
    check("full_count8", 16'(fifo_count), 16'h8);
    spike_in = 2'b01;
    step();
    spike_in = 2'b00;
    step();
    step();
    check("full_held_count", 16'(fifo_count), 16'h8);
    check("full_held_noovf", 16'(overflow), 16'h0);
    spike_in = 2'b01;
    step();
    spike_in = 2'b00;
    check("full_drop_ovf", 16'(overflow), 16'h1);
    check("full_drop_cnt", 16'(drop_cnt), 16'h01);
    ack_once();
    ack_once();
    check("full_pop_count7", 16'(fifo_count), 16'h7);
    step();
    check("full_refill_count8", 16'(fifo_count), 16'h8);
    step();
    check("full_stable_count8", 16'(fifo_count), 16'h8);

    // Status: clear, then 300 drops saturate, then clear with drop.
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("clr_ovf", 16'(overflow), 16'h0);
    check("clr_drop", 16'(drop_cnt), 16'h0);
    spike_in = 2'b01;
    step();
    check("hold_no_drop", 16'(drop_cnt), 16'h0);
    for (int i = 0; i < 300; i++) step();
    spike_in = 2'b00;
    check("sat_drop", 16'(drop_cnt), 16'hFF);
    check("sat_ovf", 16'(overflow), 16'h1);
    clear_status = 1'b1; spike_in = 2'b01;
    step();
    clear_status = 1'b0; spike_in = 2'b00;
    check("clr_coinc_drop", 16'(drop_cnt), 16'h01);
    check("clr_coinc_ovf", 16'(overflow), 16'h1);

    // Timestamp wrap: 8192 ticks, spike on unit 1 -> 0x8000.
    do_reset();
    sample_tick = 1'b1;
    for (int i = 0; i < 8192; i++) step();
    sample_tick = 1'b0;
    spike_in = 2'b10; event_in = 4'b0000;
    step();
    spike_in = 2'b00;
    step();
    check("wrap_msb", 16'(out_byte), 16'h80);
    ack_once();
    check("wrap_lsb", 16'(out_byte), 16'h00);
    check("wrap_phase", 16'(byte_phase), 16'h1);
    ack_once();

    // Reset mid-read after MSB acknowledged.
    do_reset();
    spike_in = 2'b01; event_in = 4'b0001;
    step();
    spike_in = 2'b00; event_in = 4'b0000;
    step();
    check("midrd_msb", 16'(out_byte), 16'h20);
    ack_once();
    check("midrd_phase1", 16'(byte_phase), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst_n = 1'b1;
    check_reset_outputs("post_rst");
    spike_in = 2'b01; event_in = 4'b0011;
    step();
    spike_in = 2'b00; event_in = 4'b0000;
    step();
    check("post_rst_phase", 16'(byte_phase), 16'h0);
    check("post_rst_msb", 16'(out_byte), 16'h60);
    check("post_rst_count", 16'(fifo_count), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
